gain_slew: RTL and testbench

Slew-rate limiter that sits directly downstream of the serial var/var divider in the gain-control path. The divider's quotient updates silently every NBITS+1 clocks with no valid strobe. This block filters that quotient for stability and moves a registered gain word toward it in bounded steps at audio-sample cadence, so gain changes never produce zipper noise.

---
 rtl/gain_slew_pkg.sv | 16 +
 rtl/step_prescaler.sv | 37 +++
 rtl/gain_slew.sv | 128 ++++++++++++
 tb/tb_gain_slew.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/gain_slew_pkg.sv
// Shared types and default constants for the gain slew-rate limiter.
// The fast-attack option is selected with GAIN_SLEW_FAST_ATTACK_EN (see gain_slew.sv).
package gain_slew_pkg;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_RAMP = 2'd1,
        ST_IDLE = 2'd2
    } state_t;

    localparam int DEF_NBITS         = 8;
    localparam int DEF_STEP          = 1;
    localparam int DEF_RATE_DIV      = 16;
    localparam int DEF_STABLE_CYCLES = 4;

endpackage

// File: rtl/step_prescaler.sv
// Divides sample ticks by RATE_DIV while ramping; step is a one-clock strobe that
// coincides with the RATE_DIV-th tick since the last clear.
module step_prescaler
    import gain_slew_pkg::*;
#(
    parameter int RATE_DIV = DEF_RATE_DIV
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic clear_i,
    input  logic enable_i,
    input  logic sample_tick_i,
    output logic step_o
);

    localparam int TW = $clog2(RATE_DIV + 1);

    logic [TW-1:0] tick_cnt;
    logic          at_last;

    assign at_last = (tick_cnt == TW'(RATE_DIV - 1));
    assign step_o  = enable_i & sample_tick_i & at_last;

    // Clear wins over a coincident tick, so ticks are counted strictly after RAMP entry.
    always_ff @(posedge clk_i) begin
        if (srst_i || clear_i) begin
            tick_cnt <= '0;
        end else if (enable_i && sample_tick_i) begin
            if (at_last) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
            end
        end
    end

endmodule

// File: rtl/gain_slew.sv
// Slew-rate limiter for the gain word: filters the divider quotient for stability and
// ramps gain_o toward it. Define GAIN_SLEW_FAST_ATTACK_EN to make decreases instant.
module gain_slew
    import gain_slew_pkg::*;
#(
    parameter int NBITS         = DEF_NBITS,
    parameter int STEP          = DEF_STEP,
    parameter int RATE_DIV      = DEF_RATE_DIV,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             sample_tick_i,
    input  logic [NBITS-1:0] target_i,
    output logic [NBITS-1:0] gain_o,
    output logic             settled_o,
    output logic             ramping_o
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [NBITS:0]   STEP_W = (NBITS + 1)'(STEP);
    localparam logic [NBITS-1:0] STEP_N = NBITS'(STEP);

    state_t           state_q, state_d;
    logic [NBITS-1:0] gain_q, gain_d;
    logic [NBITS-1:0] target_q, target_d;
    logic [SW-1:0]    stab_q, stab_d;
    logic             ramp_start;
    logic             step;

    logic             dir_up;
    logic [NBITS:0]   diff;
    logic             close;

    step_prescaler #(
        .RATE_DIV (RATE_DIV)
    ) u_prescaler (
        .clk_i         (clk_i),
        .srst_i        (srst_i),
        .clear_i       (ramp_start),
        .enable_i      (state_q == ST_RAMP),
        .sample_tick_i (sample_tick_i),
        .step_o        (step)
    );

    // Distance to target in NBITS+1 bits so neither direction can wrap.
    always_comb begin
        dir_up = (target_q >= gain_q);
        if (dir_up) begin
            diff = {1'b0, target_q} - {1'b0, gain_q};
        end else begin
            diff = {1'b0, gain_q} - {1'b0, target_q};
        end
        close = (diff <= STEP_W);
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q  <= ST_WAIT;
            gain_q   <= '0;
            target_q <= '0;
            stab_q   <= '0;
        end else begin
            state_q  <= state_d;
            gain_q   <= gain_d;
            target_q <= target_d;
            stab_q   <= stab_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gain_d     = gain_q;
        target_d   = target_q;
        stab_d     = stab_q;
        ramp_start = 1'b0;

        // A moving target restarts the stability filter and freezes gain, even on a step edge.
        if (target_i != target_q) begin
            target_d = target_i;
            stab_d   = '0;
            state_d  = ST_WAIT;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (stab_q == SW'(STABLE_CYCLES - 1)) begin
                        if (target_q == gain_q) begin
                            state_d = ST_IDLE;
`ifdef GAIN_SLEW_FAST_ATTACK_EN
                        end else if (target_q < gain_q) begin
                            gain_d  = target_q;
                            state_d = ST_IDLE;
`endif
                        end else begin
                            state_d    = ST_RAMP;
                            ramp_start = 1'b1;
                        end
                    end else begin
                        stab_d = stab_q + SW'(1);
                    end
                end
                ST_RAMP: begin
                    if (step) begin
                        if (close) begin
                            gain_d  = target_q;
                            state_d = ST_IDLE;
                        end else if (dir_up) begin
                            gain_d = gain_q + STEP_N;
                        end else begin
                            gain_d = gain_q - STEP_N;
                        end
                    end
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_WAIT;
                end
            endcase
        end
    end

    assign gain_o    = gain_q;
    assign settled_o = (state_q == ST_IDLE);
    assign ramping_o = (state_q == ST_RAMP);

endmodule

// File: tb/tb_gain_slew.sv
// Directed bench for gain_slew: NBITS=8, STEP=2, RATE_DIV=4, STABLE_CYCLES=4,
// sample tick every third clock.
module tb_gain_slew;

    localparam int NBITS    = 8;
    localparam int STEP     = 2;
    localparam int RATE_DIV = 4;
    localparam int STABLE   = 4;

    logic             clk = 1'b0;
    logic             srst;
    logic             sample_tick;
    logic [NBITS-1:0] target;
    logic [NBITS-1:0] gain;
    logic             settled;
    logic             ramping;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    int tick_seen = 0;
    logic last_tick;
    logic [NBITS-1:0] exp_q[$];

    gain_slew #(
        .NBITS         (NBITS),
        .STEP          (STEP),
        .RATE_DIV      (RATE_DIV),
        .STABLE_CYCLES (STABLE)
    ) dut (
        .clk_i         (clk),
        .srst_i        (srst),
        .sample_tick_i (sample_tick),
        .target_i      (target),
        .gain_o        (gain),
        .settled_o     (settled),
        .ramping_o     (ramping)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One clock: outputs are sampled 1ns after the edge, then inputs for the next edge are set.
    task automatic cyc();
        last_tick = sample_tick;
        @(posedge clk);
        #1;
        cyc_n++;
        sample_tick = (cyc_n % 3 == 0);
        if (last_tick) tick_seen++;
    endtask

    task automatic do_reset();
        srst   = 1'b1;
        target = '0;
        cyc();
        srst = 1'b0;
        repeat (STABLE) cyc();
        chk("reset_settle", 32'(settled), 32'd1);
    endtask

    // Apply a new target and check the WAIT window; the caller checks the exit edge.
    task automatic start_change(input string tag, input logic [NBITS-1:0] t,
                                input logic [NBITS-1:0] hold, input logic exp_ramp);
        target = t;
        cyc();
        chk({tag, "_e0_settled"}, 32'(settled), 32'd0);
        chk({tag, "_e0_ramping"}, 32'(ramping), 32'd0);
        chk({tag, "_e0_gain"}, 32'(gain), 32'(hold));
        repeat (STABLE - 1) begin
            cyc();
            chk({tag, "_wait_ramping"}, 32'(ramping), 32'd0);
            chk({tag, "_wait_gain"}, 32'(gain), 32'(hold));
        end
        cyc();
        chk({tag, "_exit_ramping"}, 32'(ramping), 32'(exp_ramp));
        tick_seen = 0;
    endtask

    // Follow gain changes against exp_q; each change must land on the RATE_DIV-th tick.
    task automatic watch(input string tag, input int budget, input logic final_settle);
        logic [NBITS-1:0] prev;
        int n;
        prev = gain;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            cyc();
            n++;
            if (gain !== prev) begin
                chk({tag, "_step"}, 32'(gain), 32'(exp_q.pop_front()));
                chk({tag, "_ticks"}, tick_seen, RATE_DIV);
                tick_seen = 0;
                prev = gain;
                if (exp_q.size() == 0) begin
                    chk({tag, "_settled"}, 32'(settled), 32'(final_settle));
                    chk({tag, "_ramping"}, 32'(ramping), 32'(!final_settle));
                end
            end
        end
        if (exp_q.size() > 0) begin
            chk({tag, "_timeout"}, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_ramp;
        int n;
        srst        = 1'b1;
        target      = '0;
        sample_tick = 1'b0;

        // Reset and settle with target 0
        cyc();
        cyc();
        chk("rst_gain", 32'(gain), 32'd0);
        chk("rst_settled", 32'(settled), 32'd0);
        chk("rst_ramping", 32'(ramping), 32'd0);
        srst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk("rel_settled", 32'(settled), 32'(k >= STABLE));
            chk("rel_gain", 32'(gain), 32'd0);
            chk("rel_ramping", 32'(ramping), 32'd0);
        end

        // Ramp 0 -> 10
        start_change("up10", 8'd10, 8'd0, 1'b1);
        exp_q = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd10};
        watch("up10", 200, 1'b1);

        // Ramp 0 -> 9, last step clamps
        do_reset();
        start_change("up9", 8'd9, 8'd0, 1'b1);
        exp_q = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd9};
        watch("up9", 200, 1'b1);

        // Glitch rejection
        do_reset();
        target = 8'd10;
        cyc();
        cyc();
        target = 8'd0;
        saw_ramp = 1'b0;
        repeat (12) begin
            cyc();
            if (ramping) saw_ramp = 1'b1;
        end
        chk("glitch_no_ramp", 32'(saw_ramp), 32'd0);
        chk("glitch_gain", 32'(gain), 32'd0);
        chk("glitch_settled", 32'(settled), 32'd1);

        // Mid-ramp retarget at gain 6 down to 2
        do_reset();
        start_change("rt_up", 8'd10, 8'd0, 1'b1);
        exp_q = '{8'd2, 8'd4, 8'd6};
        watch("rt_up", 200, 1'b0);
`ifdef GAIN_SLEW_FAST_ATTACK_EN
        start_change("rt_dn", 8'd2, 8'd6, 1'b0);
        chk("rt_dn_exit_gain", 32'(gain), 32'd2);
        chk("rt_dn_exit_settled", 32'(settled), 32'd1);
`else
        start_change("rt_dn", 8'd2, 8'd6, 1'b1);
        chk("rt_dn_exit_gain", 32'(gain), 32'd6);
        exp_q = '{8'd4, 8'd2};
        watch("rt_dn", 200, 1'b1);
`endif

        // Target change on the very edge a step would occur
        do_reset();
        start_change("col_up", 8'd10, 8'd0, 1'b1);
        exp_q = '{8'd2};
        watch("col_up", 200, 1'b0);
        n = 0;
        while (!(tick_seen == RATE_DIV - 1 && sample_tick) && n < 50) begin
            cyc();
            n++;
        end
        chk("col_align_timeout", 32'(n < 50), 32'd1);
        target = 8'd0;
        cyc();
        chk("col_hold_gain", 32'(gain), 32'd2);
        chk("col_hold_ramping", 32'(ramping), 32'd0);
        repeat (STABLE - 1) cyc();
`ifdef GAIN_SLEW_FAST_ATTACK_EN
        cyc();
        chk("col_fast_gain", 32'(gain), 32'd0);
        chk("col_fast_settled", 32'(settled), 32'd1);
`else
        cyc();
        chk("col_dn_ramping", 32'(ramping), 32'd1);
        tick_seen = 0;
        exp_q = '{8'd0};
        watch("col_dn", 200, 1'b1);
`endif

        // Reset mid-ramp, then restart toward the held target
        do_reset();
        start_change("sr_up", 8'd10, 8'd0, 1'b1);
        exp_q = '{8'd2, 8'd4, 8'd6};
        watch("sr_up", 200, 1'b0);
        srst = 1'b1;
        cyc();
        chk("sr_gain", 32'(gain), 32'd0);
        chk("sr_settled", 32'(settled), 32'd0);
        chk("sr_ramping", 32'(ramping), 32'd0);
        srst = 1'b0;
        for (int k = 1; k <= STABLE + 1; k++) begin
            cyc();
            chk("sr_restart_ramping", 32'(ramping), 32'(k == STABLE + 1));
        end
        tick_seen = 0;
        exp_q = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd10};
        watch("sr_re", 200, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
